// File: rtl/shift_unit_pkg.sv
// Shared types and constants for the multi-mode shift unit.
package shift_unit_pkg;

  typedef enum logic [1:0] {
    LSL = 2'd0,
    LSR = 2'd1,
    ASR = 2'd2,
    ROL = 2'd3
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

  localparam int unsigned ZERO     = 0;
  localparam int unsigned ONE      = 1;
  localparam int unsigned TWO      = 2;
  localparam logic        BIT_ZERO = 1'b0;

endpackage

// File: rtl/shift_unit_step.sv
// One-position shift of a word in the selected mode (purely combinational).
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] word,
  input  shift_mode_e   mode,
  output logic [DW-1:0] next_word_c,
  output logic          bit_out_c
);

  // Next word and the bit that leaves it for each mode
  always_comb begin
    next_word_c = word;
    bit_out_c   = BIT_ZERO;
    case (mode)
      LSL: begin
        next_word_c = {word[DW-2:0], BIT_ZERO};
        bit_out_c   = word[DW-1];
      end
      LSR: begin
        next_word_c = {BIT_ZERO, word[DW-1:1]};
        bit_out_c   = word[0];
      end
      ASR: begin
        next_word_c = {word[DW-1], word[DW-1:1]};
        bit_out_c   = word[0];
      end
      ROL: begin
        next_word_c = {word[DW-2:0], word[DW-1]};
        bit_out_c   = word[DW-1];
      end
      default: begin
        next_word_c = word;
        bit_out_c   = BIT_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-mode shift register with start/done handshake, one step per clock.
// Optional macro SHIFT_UNIT_DUAL_STEP_EN: two steps per clock while >= 2 remain.
// busy and done trail the internal state by one edge, so the visible DONE
// cycle is the one in which done is high; accept is held off while busy.
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter  int unsigned DW = 16,
  localparam int unsigned AW = $clog2(DW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] amount,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          carry,
  output logic          busy,
  output logic          done
);

  shift_state_e  state;
  shift_mode_e   mode_q;
  logic [AW-1:0] cnt;
  logic [AW-1:0] amount_sat;
  logic [DW-1:0] step1_word;
  logic          step1_bit;

  // Amounts beyond the word width behave as a full-width shift
  assign amount_sat = (amount > AW'(DW)) ? AW'(DW) : amount;

  shift_step #(.DW(DW)) u_step1 (
    .word        (data_out),
    .mode        (mode_q),
    .next_word_c (step1_word),
    .bit_out_c   (step1_bit)
  );

`ifdef SHIFT_UNIT_DUAL_STEP_EN
  logic [DW-1:0] step2_word;
  logic          step2_bit;

  shift_step #(.DW(DW)) u_step2 (
    .word        (step1_word),
    .mode        (mode_q),
    .next_word_c (step2_word),
    .bit_out_c   (step2_bit)
  );
`endif

  // Control FSM with registered datapath and status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      mode_q   <= LSL;
      cnt      <= AW'(ZERO);
      data_out <= DW'(ZERO);
      carry    <= BIT_ZERO;
      busy     <= BIT_ZERO;
      done     <= BIT_ZERO;
    end else begin
      done <= BIT_ZERO;
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          if (start && !busy) begin
            data_out <= data_in;
            carry    <= BIT_ZERO;
            mode_q   <= shift_mode_e'(mode);
            cnt      <= amount_sat;
            state    <= (amount_sat != AW'(ZERO)) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
`ifdef SHIFT_UNIT_DUAL_STEP_EN
          if (cnt >= AW'(TWO)) begin
            data_out <= step2_word;
            carry    <= step2_bit;
            cnt      <= cnt - AW'(TWO);
            if (cnt == AW'(TWO)) state <= DONE;
          end else
`endif
          begin
            data_out <= step1_word;
            carry    <= step1_bit;
            cnt      <= cnt - AW'(ONE);
            if (cnt == AW'(ONE)) state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit (DW=8) against an arithmetic reference.
module tb_shift_unit;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = $clog2(DW) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] amount;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          carry;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  shift_unit #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .amount   (amount),
    .data_in  (data_in),
    .data_out (data_out),
    .carry    (carry),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Closed-form result of shifting x by amt positions in mode m
  function automatic void ref_model(input int m, input int amt, input int x,
                                    output int res, output int cy, output int edges);
    int n;
    n = (amt > DW) ? DW : amt;
    res = x;
    cy  = 0;
    case (m)
      0: begin res = (x << n) & 'hFF; if (n > 0) cy = (x >> (DW - n)) & 1; end
      1: begin res = x >> n;          if (n > 0) cy = (x >> (n - 1)) & 1; end
      2: begin
        res = x >> n;
        if (x >= 'h80) res = res | ((('hFF << (DW - n)) & 'hFF));
        if (n > 0) cy = (x >> (n - 1)) & 1;
      end
      default: begin
        res = ((x << n) | (x >> (DW - n))) & 'hFF;
        if (n > 0) cy = (x >> (DW - n)) & 1;
      end
    endcase
`ifdef SHIFT_UNIT_DUAL_STEP_EN
    edges = (n + 1) / 2;
`else
    edges = n;
`endif
  endfunction

  // Run one operation; while busy, inputs are scrambled (or held at start=1/0xFF)
  task automatic run_op(input int m, input int amt, input int x, input bit hold);
    int res, cy, edges, k, busy_cnt;
    bit seen;
    ref_model(m, amt, x, res, cy, edges);
    start   = 1'b1;
    mode    = 2'(m);
    amount  = AW'(amt);
    data_in = DW'(x);
    tick();
    chk("busy_after_accept", 32'(busy), 0);
    k = 0; busy_cnt = 0; seen = 0;
    while (!seen && k < 40) begin
      if (hold) begin
        start = 1'b1; data_in = 8'hFF;
      end else begin
        start   = 1'($urandom_range(0, 1));
        mode    = 2'($urandom);
        amount  = AW'($urandom);
        data_in = DW'($urandom);
      end
      tick();
      k++;
      if (busy) busy_cnt++;
      if (done) seen = 1;
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 1);
    chk("done_latency", 32'(k), 32'(edges + 1));
    chk("busy_cycles", 32'(busy_cnt), 32'(edges + 1));
    chk("data_out", 32'(data_out), 32'(res));
    chk("carry", 32'(carry), 32'(cy));
    tick();
    chk("done_pulse", 32'(done), 0);
    chk("busy_clear", 32'(busy), 0);
    chk("data_hold", 32'(data_out), 32'(res));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = 2'd0; amount = '0; data_in = '0;
    repeat (3) tick();
    chk("rst_data", 32'(data_out), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b1;
    tick();

    // Directed cases from the test plan, also pinned to literal results
    run_op(0, 3, 'hA5, 0);  chk("plan_lsl", 32'(data_out), 'h28);
    run_op(2, 2, 'h90, 0);  chk("plan_asr", 32'(data_out), 'hE4);
    run_op(1, 2, 'h90, 0);  chk("plan_lsr", 32'(data_out), 'h24);
    run_op(3, 4, 'h96, 0);  chk("plan_rol", 32'(data_out), 'h69);
    run_op(3, 8, 'h96, 0);  chk("plan_rol8", 32'(data_out), 'h96);
    run_op(0, 0, 'h3C, 0);  chk("plan_amt0", 32'(data_out), 'h3C);
    run_op(1, 12, 'hB7, 0); chk("plan_sat", 32'(data_out), 'h00);
    run_op(2, 15, 'h81, 0); chk("plan_asr_sat", 32'(data_out), 'hFF);
    run_op(0, 5, 'h01, 1);  chk("plan_hold", 32'(data_out), 'h20);
    run_op(0, 5, 'hA5, 0);  chk("plan_lsl5", 32'(data_out), 'hA0);

    // Reset in the middle of a shift aborts everything
    start = 1'b1; mode = 2'd0; amount = AW'(6); data_in = 8'hFF;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_data", 32'(data_out), 0);
    chk("midrst_carry", 32'(carry), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    rst = 1'b1;
    repeat (3) tick();
    chk("midrst_idle_busy", 32'(busy), 0);
    run_op(1, 1, 'h03, 0);

    // Random operations
    for (int i = 0; i < 60; i++) begin
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 255)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
Name: shift_unit

Overview:
- Parametrised multi-mode shift register with a start/done handshake.
- Successor of the single-mode left shifter. Adds:
  - four shift modes: logical left, logical right, arithmetic right, rotate left
  - a programmable shift amount
  - a carry (last bit shifted out)
  - busy/done status
- Sits in the P01 datapath between operand registers and the multiplier/ALU control FSM.
- Executes one bit per clock.

Parameters:
- DW, 16: data width in bits; must be at least 2.
- AW, $clog2(DW)+1: shift-amount width; derived, never overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- mode  input  2  shift_mode_e: 0 LSL, 1 LSR, 2 ASR, 3 ROL
- amount  input  AW  number of bit positions to shift
- data_in  input  DW  operand, loaded on accept
- data_out  output  DW  working/result register
- carry  output  1  last bit shifted out of the word
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle completion pulse

Behaviour:
- One clock domain, clk only. Reset is synchronous and active-low: rst=0 at a rising edge of clk forces IDLE. Resulting values:
  - data_out = 0, carry = 0, busy = 0, done = 0
  - internal counter = 0
- FSM states are IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - start=1 is accepted: data_out <= data_in, carry <= 0, mode is latched.
  - The counter is loaded with min(amount, DW); amounts above DW saturate to DW.
  - Next state is SHIFT if the counter value is nonzero, otherwise DONE.
- SHIFT, each edge: one step in the latched mode, counter decremented. Leave for DONE on the edge where the counter goes 1->0.
  - LSL: data_out <= {data_out[DW-2:0], 0}; carry <= data_out[DW-1]
  - LSR: data_out <= {0, data_out[DW-1:1]}; carry <= data_out[0]
  - ASR: data_out <= {data_out[DW-1], data_out[DW-1:1]}; carry <= data_out[0]
  - ROL: data_out <= {data_out[DW-2:0], data_out[DW-1]}; carry <= data_out[DW-1]
- DONE:
  - done=1 for exactly one cycle, then unconditional return to IDLE.
  - start is ignored in DONE.
- Latency: done is high in the cycle after edge (accept edge + n + 1), where n = saturated amount. Example: amount 0 gives done the cycle after the accept edge.
- busy is 1 from the edge after accept through the DONE cycle inclusive.
- start and changes on mode/amount/data_in while busy are ignored. The latched values govern the operation in flight.
- data_out and carry hold their final values in IDLE until the next accept.
- Saturation at DW:
  - LSL/LSR give 0.
  - ASR gives all copies of the sign bit.
  - ROL returns the original word.
- rst=0 in any state, including mid-SHIFT, aborts at that edge. Reset has priority over everything.

Optional Feature:
- Macro: SHIFT_UNIT_DUAL_STEP_EN.
- Defined: in SHIFT, when counter >= 2, two steps are applied per edge and the counter drops by 2. carry takes the second bit out. Latency becomes ceil(n/2) SHIFT edges.
- Undefined: one step per edge, exactly as above.
- Port list is identical in both builds.

Decomposition:
- Pkg_Global gains:
  - typedef enum logic [1:0] shift_mode_e {LSL, LSR, ASR, ROL}
  - typedef enum logic [1:0] shift_state_e {IDLE, SHIFT, DONE}
- Existing constants (ZERO, ONE, TWO, BIT_ZERO) are reused.
- One combinational sub-module, shift_step. Inputs: word, mode. Outputs: next word, bit out.
- Instantiate shift_step twice (chained) under SHIFT_UNIT_DUAL_STEP_EN, once otherwise.

Test Plan (DW=8, single-step build unless noted):
- LSL: data_in=0xA5, amount=3 -> data_out=0x28, carry=1, done high in the cycle after edge accept+4, busy for 4 cycles.
- ASR then LSR: data_in=0x90, amount=2 -> ASR gives 0xE4, carry=0; LSR gives 0x24, carry=0.
- ROL: data_in=0x96, amount=4 -> data_out=0x69, carry=1. ROL with amount=8 -> data_out=0x96.
- Boundaries:
  - amount=0, data_in=0x3C -> done the cycle after accept, data_out=0x3C, carry=0.
  - LSR with amount=12 -> saturated to 8, data_out=0x00, 8 SHIFT cycles.
- Protocol:
  - start=1 with data_in=0xFF held throughout a busy LSL 0x01 amount 5 -> ignored, result 0x20.
  - rst=0 on the 2nd SHIFT edge -> next cycle all outputs 0 and state IDLE.
- SHIFT_UNIT_DUAL_STEP_EN build: LSL 0xA5, amount=5 -> data_out=0xA0, carry=0, done the cycle after edge accept+4.
